// File: rtl/game_hp_bar_runtime_if.sv
// game_hp_bar_runtime_if: config, gameplay and pixel bus between the game fabric and the HP bar runtime
interface game_hp_bar_runtime_if #(
    parameter int COORD_WIDTH = 10,
    parameter int HP_WIDTH    = 10,
    parameter int SENS_WIDTH  = 7
);
    logic                   tick;
    logic                   hit;
    logic                   load_cfg;
    logic                   cfg_reset_hp;
    logic [COORD_WIDTH-1:0] cfg_x;
    logic [COORD_WIDTH-1:0] cfg_y;
    logic [COORD_WIDTH-1:0] cfg_w;
    logic [COORD_WIDTH-1:0] cfg_h;
    logic [SENS_WIDTH-1:0]  cfg_sens;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [HP_WIDTH-1:0]    hp;
    logic [HP_WIDTH-1:0]    karma;
    logic                   is_player_dead;
    logic                   is_invulnerable;
    logic                   px_border;
    logic                   px_fill;
    logic                   px_karma;
    modport master (
        output tick, hit, load_cfg, cfg_reset_hp, cfg_x, cfg_y, cfg_w, cfg_h, cfg_sens, x, y,
        input  hp, karma, is_player_dead, is_invulnerable, px_border, px_fill, px_karma
    );
    modport slave (
        input  tick, hit, load_cfg, cfg_reset_hp, cfg_x, cfg_y, cfg_w, cfg_h, cfg_sens, x, y,
        output hp, karma, is_player_dead, is_invulnerable, px_border, px_fill, px_karma
    );
endinterface

// File: rtl/game_hp_bar_runtime.sv
// game_hp_bar_runtime: HP/karma/i-frame runtime with registered health-bar pixel classification
module game_hp_bar_runtime #(
    parameter int COORD_WIDTH  = 10,
    parameter int HP_WIDTH     = 10,
    parameter int SENS_WIDTH   = 7,
    parameter int BORDER       = 2,
    parameter int IFRAME_TICKS = 50,
    parameter int KARMA_EN     = 1,
    parameter int KARMA_DRAIN  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    game_hp_bar_runtime_if.slave  bus
);
    localparam int IW = IFRAME_TICKS > 1 ? $clog2(IFRAME_TICKS + 1) : 1;
    localparam int DW = KARMA_DRAIN > 1 ? $clog2(KARMA_DRAIN) : 1;
    localparam int CW = COORD_WIDTH + 2;
    localparam logic [CW-1:0] BRD = CW'(BORDER);

    typedef enum logic [1:0] {ALIVE, HURT, DEAD} state_t;

    state_t                 state_q, state_d;
    logic [COORD_WIDTH-1:0] bx_q, bx_d, by_q, by_d, bw_q, bw_d, bh_q, bh_d;
    logic [SENS_WIDTH-1:0]  sens_q, sens_d, sens_cnt_q, sens_cnt_d;
    logic [HP_WIDTH-1:0]    hp_q, hp_d, karma_q, karma_d;
    logic [IW-1:0]          iframe_q, iframe_d;
    logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
    logic                   px_border_q, px_border_d, px_fill_q, px_fill_d, px_karma_q, px_karma_d;
    logic                   dmg, drain, wrap, kadd, hdec;
    logic [1:0]             dec;
    logic [HP_WIDTH-1:0]    cfg_hp, karma_n;
    logic [CW-1:0]          px, py, bx, by, ix1, iy1, ox0, oy0, ox1, oy1, fy1, kx0, kx1;
    logic                   in_i, in_o, in_fy;

    always_comb begin
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        bw_d        = bw_q;
        bh_d        = bh_q;
        sens_d      = sens_q;
        sens_cnt_d  = sens_cnt_q;
        hp_d        = hp_q;
        karma_d     = karma_q;
        iframe_d    = iframe_q;
        drain_cnt_d = drain_cnt_q;
        dmg         = 1'b0;
        drain       = 1'b0;
        wrap        = 1'b0;
        kadd        = 1'b0;
        hdec        = 1'b0;
        dec         = 2'd0;
        karma_n     = karma_q;
        cfg_hp      = HP_WIDTH'(bus.cfg_w);
        if (bus.load_cfg) begin
            bx_d   = bus.cfg_x;
            by_d   = bus.cfg_y;
            bw_d   = bus.cfg_w;
            bh_d   = bus.cfg_h;
            sens_d = bus.cfg_sens;
            if (bus.cfg_reset_hp) begin
                hp_d       = cfg_hp;
                karma_d    = '0;
                sens_cnt_d = bus.cfg_sens;
                state_d    = ALIVE;
            end else begin
                hp_d    = hp_q > cfg_hp ? cfg_hp : hp_q;
                karma_d = karma_q > hp_d ? hp_d : karma_q;
            end
        end else if (bus.tick && state_q != DEAD) begin
            if (state_q == HURT) begin
                sens_cnt_d = sens_q;
                iframe_d   = iframe_q - IW'(1);
                state_d    = iframe_q == IW'(1) ? ALIVE : HURT;
            end else if (!bus.hit) begin
                sens_cnt_d = sens_q;
            end else if (sens_cnt_q != '0) begin
                sens_cnt_d = sens_cnt_q - SENS_WIDTH'(1);
            end else begin
                sens_cnt_d = sens_q;
                dmg        = 1'b1;
                if (IFRAME_TICKS != 0) begin
                    state_d  = HURT;
                    iframe_d = IW'(IFRAME_TICKS);
                end
            end
            if (KARMA_EN != 0) begin
                wrap        = drain_cnt_q == DW'(KARMA_DRAIN - 1);
                drain_cnt_d = wrap ? '0 : drain_cnt_q + DW'(1);
                drain       = wrap && karma_q != '0;
            end
            // karma never takes the last HP; that point falls through to a direct hit
            kadd    = dmg && KARMA_EN != 0 && hp_q != '0 && karma_q < hp_q - HP_WIDTH'(1);
            hdec    = dmg && !kadd;
            dec     = {1'b0, hdec} + {1'b0, drain};
            hp_d    = hp_q > HP_WIDTH'(dec) ? hp_q - HP_WIDTH'(dec) : '0;
            karma_n = karma_q + HP_WIDTH'(kadd) - HP_WIDTH'(drain);
            karma_d = karma_n > hp_d ? hp_d : karma_n;
            if (hp_d == '0) begin
                state_d = DEAD;
                karma_d = '0;
            end
        end
    end

    always_comb begin
        px    = CW'(bus.x);
        py    = CW'(bus.y);
        bx    = CW'(bx_q);
        by    = CW'(by_q);
        ix1   = bx + CW'(bw_q);
        iy1   = by + CW'(bh_q);
        fy1   = by + CW'(bh_q);
        ox0   = bx >= BRD ? bx - BRD : '0;
        oy0   = by >= BRD ? by - BRD : '0;
        ox1   = ix1 + BRD;
        oy1   = iy1 + BRD;
        kx0   = bx + CW'(hp_q - karma_q);
        kx1   = bx + CW'(hp_q);
        in_i  = px >= bx && px <= ix1 && py >= by && py <= iy1;
        in_o  = px >= ox0 && px <= ox1 && py >= oy0 && py <= oy1;
        in_fy = py >= by && py < fy1;
        px_border_d = in_o && !in_i;
        px_fill_d   = in_fy && px >= bx && px < kx0;
        px_karma_d  = in_fy && px >= kx0 && px < kx1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ALIVE;
            bx_q        <= '0;
            by_q        <= '0;
            bw_q        <= '0;
            bh_q        <= '0;
            sens_q      <= '0;
            sens_cnt_q  <= '1;
            hp_q        <= '0;
            karma_q     <= '0;
            iframe_q    <= '0;
            drain_cnt_q <= '0;
            px_border_q <= 1'b0;
            px_fill_q   <= 1'b0;
            px_karma_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            bw_q        <= bw_d;
            bh_q        <= bh_d;
            sens_q      <= sens_d;
            sens_cnt_q  <= sens_cnt_d;
            hp_q        <= hp_d;
            karma_q     <= karma_d;
            iframe_q    <= iframe_d;
            drain_cnt_q <= drain_cnt_d;
            px_border_q <= px_border_d;
            px_fill_q   <= px_fill_d;
            px_karma_q  <= px_karma_d;
        end
    end

    assign bus.hp              = hp_q;
    assign bus.karma           = karma_q;
    assign bus.is_player_dead  = state_q == DEAD;
    assign bus.is_invulnerable = state_q == HURT;
    assign bus.px_border       = px_border_q;
    assign bus.px_fill         = px_fill_q;
    assign bus.px_karma        = px_karma_q;
endmodule

// File: tb/tb_game_hp_bar_runtime.sv
// tb_game_hp_bar_runtime: directed + randomized checks of the HP bar runtime against a rule-level model
module tb_game_hp_bar_runtime;
    localparam int CW  = 10;
    localparam int HW  = 10;
    localparam int SW  = 7;
    localparam int B   = 2;
    localparam int IFR = 4;
    localparam int KE  = 1;
    localparam int KD  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_hp_bar_runtime_if #(.COORD_WIDTH(CW), .HP_WIDTH(HW), .SENS_WIDTH(SW)) bus ();
    game_hp_bar_runtime #(
        .COORD_WIDTH(CW), .HP_WIDTH(HW), .SENS_WIDTH(SW), .BORDER(B),
        .IFRAME_TICKS(IFR), .KARMA_EN(KE), .KARMA_DRAIN(KD)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int m_bx, m_by, m_bw, m_bh, m_sens, m_hp, m_karma, m_cnt, m_ifr, m_drain, m_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int inr(int v, int lo, int hi);
        return (v >= lo && v <= hi) ? 1 : 0;
    endfunction

    task automatic step(input bit rnd);
        int eb, ef, ek, px, py, lo, hi, dmg, dr, kadd, hdec, inner, outer, fy;
        if (rnd) begin
            lo = m_bx > 4 ? m_bx - 4 : 0;
            hi = m_bx + m_bw + 4 > 1023 ? 1023 : m_bx + m_bw + 4;
            bus.x = CW'($urandom_range(hi, lo));
            lo = m_by > 4 ? m_by - 4 : 0;
            hi = m_by + m_bh + 4 > 1023 ? 1023 : m_by + m_bh + 4;
            bus.y = CW'($urandom_range(hi, lo));
        end
        px = int'(bus.x);
        py = int'(bus.y);
        outer = inr(px, m_bx - B < 0 ? 0 : m_bx - B, m_bx + m_bw + B) & inr(py, m_by - B < 0 ? 0 : m_by - B, m_by + m_bh + B);
        inner = inr(px, m_bx, m_bx + m_bw) & inr(py, m_by, m_by + m_bh);
        fy = (py >= m_by && py < m_by + m_bh) ? 1 : 0;
        eb = (outer == 1 && inner == 0) ? 1 : 0;
        ef = (fy == 1 && px >= m_bx && px < m_bx + m_hp - m_karma) ? 1 : 0;
        ek = (fy == 1 && px >= m_bx + m_hp - m_karma && px < m_bx + m_hp) ? 1 : 0;
        if (reset) begin
            eb = 0;
            ef = 0;
            ek = 0;
        end
        @(posedge clk);
        if (reset) begin
            m_bx = 0; m_by = 0; m_bw = 0; m_bh = 0; m_sens = 0;
            m_hp = 0; m_karma = 0; m_cnt = (1 << SW) - 1; m_ifr = 0; m_drain = 0; m_mode = 0;
        end else if (bus.load_cfg) begin
            m_bx = int'(bus.cfg_x); m_by = int'(bus.cfg_y);
            m_bw = int'(bus.cfg_w); m_bh = int'(bus.cfg_h); m_sens = int'(bus.cfg_sens);
            if (bus.cfg_reset_hp) begin
                m_hp = m_bw; m_karma = 0; m_cnt = m_sens; m_mode = 0;
            end else begin
                if (m_hp > m_bw) m_hp = m_bw;
                if (m_karma > m_hp) m_karma = m_hp;
            end
        end else if (bus.tick && m_mode != 2) begin
            dmg = 0;
            dr = 0;
            if (m_mode == 1) begin
                m_cnt = m_sens;
                if (m_ifr == 1) m_mode = 0;
                m_ifr--;
            end else if (!bus.hit) m_cnt = m_sens;
            else if (m_cnt > 0) m_cnt--;
            else begin
                m_cnt = m_sens;
                dmg = 1;
                if (IFR > 0) begin
                    m_mode = 1;
                    m_ifr = IFR;
                end
            end
            if (KE != 0) begin
                if (m_drain == KD - 1) begin
                    m_drain = 0;
                    dr = m_karma > 0 ? 1 : 0;
                end else m_drain++;
            end
            kadd = (dmg == 1 && KE != 0 && m_karma < m_hp - 1) ? 1 : 0;
            hdec = dmg - kadd;
            m_hp = m_hp - hdec - dr;
            if (m_hp < 0) m_hp = 0;
            m_karma = m_karma + kadd - dr;
            if (m_karma > m_hp) m_karma = m_hp;
            if (m_hp == 0) begin
                m_mode = 2;
                m_karma = 0;
            end
        end
        #1;
        chk("hp", 32'(bus.hp), m_hp);
        chk("karma", 32'(bus.karma), m_karma);
        chk("dead", 32'(bus.is_player_dead), m_mode == 2);
        chk("invuln", 32'(bus.is_invulnerable), m_mode == 1);
        chk("px_border", 32'(bus.px_border), eb);
        chk("px_fill", 32'(bus.px_fill), ef);
        chk("px_karma", 32'(bus.px_karma), ek);
    endtask

    task automatic cfg(input int cx, cy, cw, ch, cs, input bit rh);
        bus.cfg_x = CW'(cx); bus.cfg_y = CW'(cy); bus.cfg_w = CW'(cw); bus.cfg_h = CW'(ch);
        bus.cfg_sens = SW'(cs); bus.cfg_reset_hp = rh; bus.load_cfg = 1'b1;
        step(1'b1);
        bus.load_cfg = 1'b0;
        bus.cfg_reset_hp = 1'b0;
    endtask

    task automatic ticks(input int n, input bit h);
        bus.hit = h;
        bus.tick = 1'b1;
        for (int i = 0; i < n; i++) step(1'b1);
        bus.tick = 1'b0;
    endtask

    task automatic px_at(input int px, py);
        bus.x = CW'(px);
        bus.y = CW'(py);
        step(1'b0);
        step(1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.tick = 0; bus.hit = 0; bus.load_cfg = 0; bus.cfg_reset_hp = 0;
        bus.cfg_x = 0; bus.cfg_y = 0; bus.cfg_w = 0; bus.cfg_h = 0; bus.cfg_sens = 0;
        bus.x = 0; bus.y = 0;
        step(1'b1);
        step(1'b1);
        chk("rst_hp", 32'(bus.hp), 0);
        chk("rst_sens_cnt", 32'(dut.sens_cnt_q), (1 << SW) - 1);
        reset = 1'b0;
        step(1'b1);

        // first damage needs sens+1 held ticks and lands in the karma pool
        cfg(1, 1, 100, 8, 3, 1'b1);
        ticks(3, 1'b1);
        chk("t1_pre_inv", 32'(bus.is_invulnerable), 0);
        ticks(1, 1'b1);
        chk("t1_karma", 32'(bus.karma), 1);
        chk("t1_hp", 32'(bus.hp), 100);
        chk("t1_inv", 32'(bus.is_invulnerable), 1);
        ticks(IFR - 1, 1'b1);
        chk("t2_still_hurt", 32'(bus.is_invulnerable), 1);
        ticks(1, 1'b1);
        chk("t2_alive", 32'(bus.is_invulnerable), 0);
        ticks(3, 1'b1);
        chk("t2_no_dmg_yet", 32'(bus.is_invulnerable), 0);
        ticks(1, 1'b1);
        chk("t2_resume", 32'(bus.is_invulnerable), 1);

        // karma builds faster than it drains, then drains out with hp
        cfg(1, 1, 100, 8, 0, 1'b1);
        ticks(60, 1'b1);
        chk("t3_karma_built", 32'(bus.karma > 1), 1);
        for (int i = 0; i < 20; i++) step(1'b1);
        ticks(120, 1'b0);
        chk("t3_karma_zero", 32'(bus.karma), 0);
        chk("t3_hp_drop", 32'(bus.hp < 100), 1);

        cfg(1, 1, 20, 8, 0, 1'b1);
        ticks(1, 1'b1);
        px_at(0, 0);
        chk("t5_border00", 32'(bus.px_border), 1);
        px_at(5, 3);
        chk("t5_fill", 32'(bus.px_fill), 1);
        px_at(20, 3);
        chk("t5_karma", 32'(bus.px_karma), 1);
        px_at(23, 3);
        chk("t5_border_r", 32'(bus.px_border), 1);
        px_at(24, 3);
        px_at(17, 9);
        px_at(21, 9);
        cfg(0, 0, 20, 8, 0, 1'b0);
        px_at(1023, 1023);
        chk("t5_nowrap", 32'(bus.px_border), 0);

        cfg(1, 1, 100, 8, 0, 1'b1);
        bus.cfg_x = 1; bus.cfg_y = 1; bus.cfg_w = 50; bus.cfg_h = 8; bus.cfg_sens = 0;
        bus.cfg_reset_hp = 0; bus.load_cfg = 1; bus.tick = 1; bus.hit = 1;
        step(1'b1);
        bus.load_cfg = 0; bus.tick = 0; bus.hit = 0;
        chk("t6_hp", 32'(bus.hp), 50);
        chk("t6_no_hurt", 32'(bus.is_invulnerable), 0);

        cfg(1, 1, 2, 8, 0, 1'b1);
        bus.hit = 1;
        bus.tick = 1;
        for (int i = 0; i < 200 && m_mode != 2; i++) step(1'b1);
        chk("t4_dead", 32'(bus.is_player_dead), 1);
        chk("t4_hp0", 32'(bus.hp), 0);
        ticks(20, 1'b1);
        chk("t4_stays0", 32'(bus.hp), 0);
        cfg(1, 1, 30, 8, 1, 1'b1);
        chk("t4_revive", 32'(bus.is_player_dead), 0);

        for (int i = 0; i < 3000; i++) begin
            bus.tick = $urandom_range(1, 0) == 1;
            bus.hit = $urandom_range(2, 0) != 0;
            if ($urandom_range(99, 0) == 0 || (m_mode == 2 && $urandom_range(9, 0) == 0)) begin
                bus.cfg_x = CW'($urandom_range(300, 0)); bus.cfg_y = CW'($urandom_range(300, 0));
                bus.cfg_w = CW'($urandom_range(200, 1)); bus.cfg_h = CW'($urandom_range(20, 1));
                bus.cfg_sens = SW'($urandom_range(5, 0));
                bus.cfg_reset_hp = m_mode == 2 || $urandom_range(1, 0) == 1;
                bus.load_cfg = 1;
            end
            step(1'b1);
            bus.load_cfg = 0;
            bus.cfg_reset_hp = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
